// File: rtl/gamma_pi2_stage.sv
// Gamma (optionally followed by pi2) nonlinear stage on a 3x32-bit state,
// registered behind a two-entry skid buffer with a registered iready.
module gamma_pi2_stage #(
  parameter bit PI2_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] iword,
  input  logic        ivalid,
  output logic        iready,
  output logic [95:0] oword,
  output logic        ovalid,
  input  logic        oready,
  output logic [15:0] ocount
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [95:0] main_q, main_d;
  logic [95:0] skid_q, skid_d;
  logic [15:0] ocount_q, ocount_d;
  logic        iready_q, iready_d;

  logic [31:0] a0, a1, a2;
  logic [31:0] g0, g1, g2;
  logic [95:0] xform;
  logic        accept, xfer;

  always_comb begin
    a0 = iword[31:0];
    a1 = iword[63:32];
    a2 = iword[95:64];
    g0 = a0 ^ (a1 | ~a2);
    g1 = a1 ^ (a2 | ~a0);
    g2 = a2 ^ (a0 | ~a1);
    if (PI2_EN) begin
      xform = {{g2[9:0], g2[31:10]}, g1, {g0[30:0], g0[31]}};
    end else begin
      xform = {g2, g1, g0};
    end
  end

  assign ovalid = (state_q != S_EMPTY);
  assign iready = iready_q;
  assign oword  = main_q;
  assign ocount = ocount_q;
  assign accept = ivalid && iready_q;
  assign xfer   = ovalid && oready;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    ocount_d = ocount_q;
    if (xfer) begin
      ocount_d = ocount_q + 16'd1;
    end
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = xform;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && xfer) begin
          main_d = xform;
        end else if (accept) begin
          skid_d  = xform;
          state_d = S_FULL;
        end else if (xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // iready is low here, so only a drain can happen.
        if (xfer) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    iready_d = (state_d != S_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data entries are reset too, so oword reads zero after reset rather than stale data.
      state_q  <= S_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      ocount_q <= '0;
      iready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      ocount_q <= ocount_d;
      iready_q <= iready_d;
    end
  end

endmodule

// File: tb/tb_gamma_pi2_stage.sv
// Directed bench for gamma_pi2_stage: reset, known vectors, backpressure,
// mid-operation reset, 100-word stream and ocount wrap.
module tb_gamma_pi2_stage;

  logic        clk;
  logic        rst;
  logic [95:0] iword;
  logic        ivalid;
  logic        oready;
  logic        iready, iready0;
  logic [95:0] oword, oword0;
  logic        ovalid, ovalid0;
  logic [15:0] ocount, ocount0;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [95:0] ONES  = {96{1'b1}};
  localparam logic [95:0] W0ONE = 96'h00000000_00000000_00000001;

  gamma_pi2_stage #(.PI2_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .iword(iword), .ivalid(ivalid), .iready(iready),
    .oword(oword), .ovalid(ovalid), .oready(oready), .ocount(ocount)
  );

  gamma_pi2_stage #(.PI2_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .iword(iword), .ivalid(ivalid), .iready(iready0),
    .oword(oword0), .ovalid(ovalid0), .oready(oready), .ocount(ocount0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [95:0] model(input logic [95:0] w, input bit pi2);
    logic [31:0] x0, x1, x2, y0, y1, y2;
    x0 = w[31:0];
    x1 = w[63:32];
    x2 = w[95:64];
    y0 = x0 ^ (x1 | ~x2);
    y1 = x1 ^ (x2 | ~x0);
    y2 = x2 ^ (x0 | ~x1);
    if (pi2) begin
      y0 = (y0 << 1) | (y0 >> 31);
      y2 = (y2 << 22) | (y2 >> 10);
    end
    return {y2, y1, y0};
  endfunction

  logic [95:0] vec [100];

  initial begin
    rst    = 1'b1;
    iword  = '0;
    ivalid = 1'b0;
    oready = 1'b0;
    @(negedge clk);
    step();
    check("rst_ovalid", 96'(ovalid), 96'(0));
    check("rst_iready", 96'(iready), 96'(1));
    check("rst_ocount", 96'(ocount), 96'(0));
    check("rst_oword",  oword, 96'h0);
    rst = 1'b0;

    // Zero input with one-cycle latency.
    iword = '0; ivalid = 1'b1; oready = 1'b1;
    step();
    ivalid = 1'b0;
    check("zero_oword",  oword, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF);
    check("zero_ovalid", 96'(ovalid), 96'(1));
    check("zero_cnt_pre", 96'(ocount), 96'(0));
    step();
    check("zero_ocount", 96'(ocount), 96'(1));
    check("zero_drained", 96'(ovalid), 96'(0));

    // All ones and word0=1, both parameterisations.
    iword = ONES; ivalid = 1'b1;
    step();
    check("ones_pi2", oword, 96'h0);
    check("ones_nopi2", oword0, 96'h0);
    iword = W0ONE;
    step();
    ivalid = 1'b0;
    check("w0_pi2",   oword,  96'hFFFFFFFF_FFFFFFFE_FFFFFFFD);
    check("w0_nopi2", oword0, 96'hFFFFFFFF_FFFFFFFE_FFFFFFFE);
    step();
    check("w0_ocount", 96'(ocount), 96'(3));

    // Backpressure: A=0 -> all F, B=ones -> 0, C must be refused.
    oready = 1'b0; ivalid = 1'b1; iword = '0;
    step();
    check("bp_a_oword", oword, ONES);
    check("bp_a_iready", 96'(iready), 96'(1));
    iword = ONES;
    step();
    check("bp_full_iready", 96'(iready), 96'(0));
    check("bp_full_oword", oword, ONES);
    iword = W0ONE;
    step();
    check("bp_c_held_oword", oword, ONES);
    check("bp_c_iready", 96'(iready), 96'(0));
    check("bp_c_ocount", 96'(ocount), 96'(3));
    ivalid = 1'b0; oready = 1'b1;
    check("bp_first_out", oword, ONES);
    step();
    check("bp_second_out", oword, 96'h0);
    check("bp_second_ovalid", 96'(ovalid), 96'(1));
    check("bp_iready_back", 96'(iready), 96'(1));
    check("bp_ocount4", 96'(ocount), 96'(4));
    step();
    check("bp_no_c", 96'(ovalid), 96'(0));
    check("bp_ocount5", 96'(ocount), 96'(5));

    // Reset from FULL.
    oready = 1'b0; ivalid = 1'b1; iword = '0;
    step();
    iword = W0ONE;
    step();
    check("mid_full", 96'(iready), 96'(0));
    rst = 1'b1; ivalid = 1'b0;
    step();
    rst = 1'b0;
    check("mid_ovalid", 96'(ovalid), 96'(0));
    check("mid_iready", 96'(iready), 96'(1));
    check("mid_ocount", 96'(ocount), 96'(0));
    oready = 1'b1; ivalid = 1'b1; iword = ONES;
    step();
    ivalid = 1'b0;
    check("mid_new_oword", oword, 96'h0);
    step();
    check("mid_alone", 96'(ovalid), 96'(0));
    check("mid_ocount1", 96'(ocount), 96'(1));

    // 100-word stream from ocount=0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) vec[i] = {$urandom, $urandom, $urandom};
    ivalid = 1'b1; oready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      iword = vec[i];
      step();
      check($sformatf("stream_%0d", i), oword, model(vec[i], 1'b1));
      check($sformatf("stream_nopi2_%0d", i), oword0, model(vec[i], 1'b0));
    end
    ivalid = 1'b0;
    step();
    check("stream_ocount", 96'(ocount), 96'(100));

    // Wrap: 65436 more transfers brings the total to 65536.
    ivalid = 1'b1; iword = '0;
    repeat (65436) step();
    ivalid = 1'b0;
    step();
    check("wrap_zero", 96'(ocount), 96'(0));
    check("wrap_idle", 96'(ovalid), 96'(0));
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    step();
    check("wrap_one", 96'(ocount), 96'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gamma_pi2_stage.md
GAMMA_PI2_STAGE -- requirements
Module: gamma_pi2_stage

Interface
REQ-001 SHALL have parameter PI2_EN, default 1, meaning pi2 rotations are applied after gamma (0 = gamma only).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port iword, input, 96 bits, the pi1 result; word0=[31:0], word1=[63:32], word2=[95:64].
REQ-005 SHALL have port ivalid, input, 1 bit, iword valid.
REQ-006 SHALL have port iready, output, 1 bit, stage can accept.
REQ-007 SHALL have port oword, output, 96 bits, the gamma(+pi2) result, same word packing as iword.
REQ-008 SHALL have port ovalid, output, 1 bit, oword valid.
REQ-009 SHALL have port oready, input, 1 bit, downstream accepts.
REQ-010 SHALL have port ocount, output, 16 bits, number of completed output transfers.

Function
REQ-011 SHALL compute gamma from the original words: g0=a0^(a1|~a2), g1=a1^(a2|~a0), g2=a2^(a0|~a1), bitwise on 32 bits.
REQ-012 SHALL, when PI2_EN=1, output word0=rotl(g0,1), word1=g1, word2=rotl(g2,22); when PI2_EN=0, output g0,g1,g2 unchanged.
REQ-013 SHALL compute the transform on input and register the result; input acceptance is ivalid&&iready, output transfer is ovalid&&oready.
REQ-014 SHALL hold two 96-bit entries: MAIN (drives oword) and SKID; state is EMPTY, ONE (MAIN full) or FULL (MAIN and SKID full).
REQ-015 SHALL drive iready = (state != FULL) from a register, with no combinational path from oready to iready.
REQ-016 SHALL have 1-cycle latency: a word accepted in cycle N appears on oword with ovalid=1 in cycle N+1 when MAIN was empty or drained in cycle N.
REQ-017 SHALL make these transitions: EMPTY+accept -> ONE; ONE+accept, no transfer -> FULL (word into SKID); ONE+transfer, no accept -> EMPTY; ONE+accept+transfer -> ONE (new word into MAIN); FULL+transfer -> ONE (SKID moves to MAIN); otherwise hold.
REQ-018 SHALL, in FULL, ignore iword/ivalid, because iready=0.
REQ-019 SHALL hold oword and ovalid stable while ovalid=1 and oready=0.
REQ-020 SHALL preserve order: output order equals acceptance order, with no loss or duplication.
REQ-021 SHALL increment ocount by 1 on each output transfer, wrapping from 0xFFFF to 0x0000.
REQ-022 SHALL not update MAIN, SKID or ocount on ivalid with iready=0, or on oready with ovalid=0.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state EMPTY, ovalid=0, iready=1, ocount=0, oword=96'h0, and SKID=0.
REQ-024 SHALL give rst priority over a simultaneous accept or transfer; data held at reset is discarded and not counted.
REQ-025 SHALL accept input from the first edge after rst deasserts.

Verification
REQ-026 Zero input: iword=96'h0, ivalid=1, oready=1 -> next cycle oword=96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, ovalid=1, ocount=1 after transfer.
REQ-027 All ones: iword=all ones -> oword=96'h0; word0=1, others 0 -> oword words (w0,w1,w2)=(FFFFFFFD,FFFFFFFE,FFFFFFFF) for PI2_EN=1 and (FFFFFFFE,FFFFFFFE,FFFFFFFF) for PI2_EN=0.
REQ-028 Backpressure: oready=0, push A then B -> iready=0 after B, oword=f(A) held stable, C is not accepted; then oready=1 -> f(A), then f(B), in order; iready returns to 1.
REQ-029 Streaming: ivalid=oready=1 for 100 cycles with the stimulus file vectors -> one output per cycle, matches the C-model gamma/pi2 results, ocount=100.
REQ-030 Reset mid-operation: FULL state, then rst=1 for one cycle -> ovalid=0, iready=1, ocount=0; the next accepted word appears alone with no stale data.
REQ-031 Wrap: 65536 transfers -> ocount=0x0000; transfer 65537 -> ocount=0x0001.
